// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues one-outstanding imem word requests, feeds decode (optional FETCH_MISALIGN_EN).
// Latency: reset release -> first imem_req 1 cycle; imem_rvalid -> ValidF 1 cycle (registered outputs).
// Backpressure: StallF holds the bundle; one returned word is parked in a single-entry buffer, no new request until it drains.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCplus4F,
    output logic        ValidF
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FULL  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] inflight_pc, inflight_pc_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] pc_q, pc_n;
    logic        valid_q, valid_n;
    logic [31:0] target_pc;
    logic        halt;
    logic        granted;
    logic        slot_free;

`ifdef FETCH_MISALIGN_EN
    logic misalign_q, misalign_n;

    assign target_pc = redirect_pc;
    assign halt      = misalign_q;
    assign misalign  = misalign_q;
`else
    logic unused_pc_lsbs;

    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign halt           = 1'b0;
    assign unused_pc_lsbs = ^redirect_pc[1:0];
`endif

    assign slot_free = !valid_q || !StallF;

    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        inflight_pc_n = inflight_pc;
        buf_instr_n   = buf_instr;
        instr_n       = instr_q;
        pc_n          = pc_q;
        valid_n       = valid_q;
        imem_req      = 1'b0;
        granted       = 1'b0;
`ifdef FETCH_MISALIGN_EN
        misalign_n    = misalign_q;
`endif

        // Decode takes the bundle at this edge; a load below may refill it.
        if (valid_q && !StallF) begin
            valid_n = 1'b0;
            instr_n = NOP_INSTR;
        end

        case (state)
            IDLE: begin
                state_n = REQ;
            end
            REQ: begin
                imem_req = !halt;
                if (!halt && imem_gnt) begin
                    granted       = 1'b1;
                    inflight_pc_n = fetch_pc;
                    fetch_pc_n    = fetch_pc + 32'd4;
                    state_n       = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (slot_free) begin
                        instr_n = imem_rdata;
                        pc_n    = inflight_pc;
                        valid_n = 1'b1;
                        state_n = REQ;
                    end else begin
                        buf_instr_n = imem_rdata;
                        state_n     = FULL;
                    end
                end
            end
            FULL: begin
                if (!StallF) begin
                    instr_n = buf_instr;
                    pc_n    = inflight_pc;
                    valid_n = 1'b1;
                    state_n = REQ;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_n = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A stale response landing in the same cycle as the redirect is dropped
        // right here, so DRAIN is only entered when one is still on its way.
        if (redirect && state != IDLE) begin
            fetch_pc_n  = target_pc;
            valid_n     = 1'b0;
            instr_n     = NOP_INSTR;
            pc_n        = pc_q;
            buf_instr_n = NOP_INSTR;
            if (granted || ((state == WAIT || state == DRAIN) && !imem_rvalid)) begin
                state_n = DRAIN;
            end else begin
                state_n = REQ;
            end
`ifdef FETCH_MISALIGN_EN
            misalign_n = (target_pc[1:0] != 2'b00);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            buf_instr   <= NOP_INSTR;
            instr_q     <= NOP_INSTR;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            inflight_pc <= inflight_pc_n;
            buf_instr   <= buf_instr_n;
            instr_q     <= instr_n;
            pc_q        <= pc_n;
            valid_q     <= valid_n;
`ifdef FETCH_MISALIGN_EN
            misalign_q  <= misalign_n;
`endif
        end
    end

    assign imem_addr = fetch_pc;
    assign InstrF    = instr_q;
    assign PCF       = pc_q;
    assign PCplus4F  = pc_q + 32'd4;
    assign ValidF    = valid_q;

`ifndef SYNTHESIS
    // Memory must only answer while a request is actually outstanding.
    rvalid_only_when_outstanding: assert property (
        @(posedge clk) disable iff (rst)
        imem_rvalid |-> (state == WAIT || state == DRAIN)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder plus scoreboard of expected fetch bundles.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pcf;
    logic [31:0] pc4f;
    logic        validf;

    logic        w_rst;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pcf;
    logic [31:0] w_pc4f;
    logic        w_valid;
    logic        w_zero;
    logic [31:0] w_zero32;

`ifdef FETCH_MISALIGN_EN
    logic        misalign;
    logic        w_misalign;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk         (clk),
`ifdef FETCH_MISALIGN_EN
        .misalign    (misalign),
`endif
        .rst         (rst),
        .StallF      (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrF      (instr),
        .PCF         (pcf),
        .PCplus4F    (pc4f),
        .ValidF      (validf)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
`ifdef FETCH_MISALIGN_EN
        .misalign    (w_misalign),
`endif
        .rst         (w_rst),
        .StallF      (w_zero),
        .redirect    (w_zero),
        .redirect_pc (w_zero32),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_gnt    (w_gnt),
        .imem_rvalid (w_rvalid),
        .imem_rdata  (w_rdata),
        .InstrF      (w_instr),
        .PCF         (w_pcf),
        .PCplus4F    (w_pc4f),
        .ValidF      (w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          cyc;
    int          n_consumed;
    int          rsp_delay;
    logic        gnt_en;
    logic        drop_en;
    logic [31:0] drop_addr;
    logic [31:0] rsp_q[$];
    int          rsp_due_q[$];
    logic [31:0] issued_q[$];
    logic [31:0] sb_q[$];

    // One clock: memory answers for the current cycle, finished bundles are scored,
    // then the bench moves to the next falling edge.
    task automatic tick();
        logic        hs;
        logic [31:0] hs_addr;
        logic [31:0] a;
        logic [31:0] e;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (rsp_q.size() > 0 && rsp_due_q[0] <= cyc) begin
            a = rsp_q.pop_front();
            void'(rsp_due_q.pop_front());
            imem_rvalid = 1'b1;
            imem_rdata  = ~a;
            if (drop_en && a == drop_addr) drop_en = 1'b0;
            else sb_q.push_back(a);
        end
        imem_gnt = gnt_en;
        hs       = !rst && (imem_req === 1'b1) && gnt_en;
        hs_addr  = imem_addr;
        if (!rst && validf === 1'b1 && !stall) begin
            n_consumed++;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL bundle_unexpected: got PCF=%h, expected no bundle", pcf);
            end else begin
                e = sb_q.pop_front();
                if (pcf !== e || pc4f !== e + 32'd4 || instr !== ~e) begin
                    n_err++;
                    $display("FAIL bundle: got PCF=%h PC+4=%h instr=%h, expected %h %h %h",
                             pcf, pc4f, instr, e, e + 32'd4, ~e);
                end
            end
        end
        @(negedge clk);
        cyc++;
        if (hs) begin
            issued_q.push_back(hs_addr);
            rsp_q.push_back(hs_addr);
            rsp_due_q.push_back(cyc + rsp_delay);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        gnt_en      = 1'b0;
        drop_en     = 1'b0;
        rsp_delay   = 0;
        n_consumed  = 0;
        rsp_q.delete();
        rsp_due_q.delete();
        issued_q.delete();
        sb_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain_and_check(input string name, input int exp_consumed);
        gnt_en = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (sb_q.size() != 0 || n_consumed != exp_consumed) begin
            n_err++;
            $display("FAIL %s_drain: got pending=%0d consumed=%0d, expected 0 and %0d",
                     name, sb_q.size(), n_consumed, exp_consumed);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (imem_req !== 1'b0 || validf !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl: got req=%b valid=%b, expected 0 0", imem_req, validf);
        end
        n_cmp++;
        if (instr !== NOP || pcf !== 32'h0 || pc4f !== 32'h4) begin
            n_err++; $display("FAIL reset_bundle: got %h %h %h, expected %h 0 4", instr, pcf, pc4f, NOP);
        end
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL first_req: got req=%b addr=%h, expected 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        do_reset();
        gnt_en = 1'b1;
        for (int i = 0; i < 40 && issued_q.size() < 3; i++) tick();
        gnt_en = 1'b0;
        n_cmp++;
        if (issued_q.size() != 3) begin
            n_err++; $display("FAIL basic_timeout: got %0d requests, expected 3", issued_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (issued_q[i] !== 32'(i * 4)) begin
                    n_err++; $display("FAIL basic_addr%0d: got %h, expected %h", i, issued_q[i], 32'(i * 4));
                end
            end
        end
        drain_and_check("basic", 3);
    endtask

    task automatic test_stall();
        do_reset();
        gnt_en = 1'b1;
        for (int i = 0; i < 40 && !(validf === 1'b1 && pcf == 32'h4); i++) tick();
        n_cmp++;
        if (!(validf === 1'b1 && pcf == 32'h4)) begin
            n_err++; $display("FAIL stall_timeout: got PCF=%h valid=%b, expected 00000004 1", pcf, validf);
        end
        stall = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (imem_req !== 1'b0 || validf !== 1'b1 || pcf !== 32'h4 || instr !== ~32'h4) begin
                n_err++;
                $display("FAIL stall_hold%0d: got req=%b valid=%b PCF=%h instr=%h, expected 0 1 4 %h",
                         i, imem_req, validf, pcf, instr, ~32'h4);
            end
            if (i == 0) tick();
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (validf !== 1'b1 || pcf !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            n_err++;
            $display("FAIL stall_release: got valid=%b PCF=%h req=%b addr=%h, expected 1 8 1 C",
                     validf, pcf, imem_req, imem_addr);
        end
        drain_and_check("stall", 3);
    endtask

    task automatic test_redirect();
        logic [31:0] tgt;
`ifdef FETCH_MISALIGN_EN
        tgt = 32'h100;
`else
        tgt = 32'h103;
`endif
        do_reset();
        rsp_delay = 1;
        gnt_en    = 1'b1;
        for (int i = 0; i < 60 && !(issued_q.size() > 0 && issued_q[$] == 32'h10); i++) tick();
        n_cmp++;
        if (!(issued_q.size() > 0 && issued_q[$] == 32'h10)) begin
            n_err++; $display("FAIL redir_timeout: got %0d requests, expected one for 00000010", issued_q.size());
        end
        redirect    = 1'b1;
        redirect_pc = tgt;
        drop_en     = 1'b1;
        drop_addr   = 32'h10;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (validf !== 1'b0 || instr !== NOP || imem_req !== 1'b0) begin
            n_err++; $display("FAIL redir_kill: got valid=%b instr=%h req=%b, expected 0 %h 0", validf, instr, imem_req, NOP);
        end
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || drop_en !== 1'b0) begin
            n_err++;
            $display("FAIL redir_target: got req=%b addr=%h stale_pending=%b, expected 1 100 0", imem_req, imem_addr, drop_en);
        end
        for (int i = 0; i < 20 && validf !== 1'b1; i++) tick();
        n_cmp++;
        if (validf !== 1'b1 || pcf !== 32'h100) begin
            n_err++; $display("FAIL redir_first: got valid=%b PCF=%h, expected 1 100", validf, pcf);
        end
        gnt_en = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL redir_drain: got %0d pending bundles, expected 0", sb_q.size());
        end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || validf !== 1'b0) begin
                n_err++;
                $display("FAIL nognt_%0d: got req=%b addr=%h valid=%b, expected 1 0 0", i, imem_req, imem_addr, validf);
            end
            tick();
        end
        gnt_en = 1'b1;
        for (int i = 0; i < 40 && issued_q.size() < 2; i++) tick();
        gnt_en = 1'b0;
        n_cmp++;
        if (issued_q.size() != 2 || issued_q[0] !== 32'h0 || issued_q[1] !== 32'h4) begin
            n_err++; $display("FAIL nognt_resume: got %0d requests, expected 00000000 then 00000004", issued_q.size());
        end
        drain_and_check("nognt", 2);
    endtask

    task automatic test_wrap();
        w_rst = 1'b1;
        tick();
        n_cmp++;
        if (w_pcf !== 32'hFFFF_FFFC || w_pc4f !== 32'h0 || w_valid !== 1'b0) begin
            n_err++; $display("FAIL wrap_reset: got PCF=%h PC+4=%h valid=%b, expected FFFFFFFC 0 0", w_pcf, w_pc4f, w_valid);
        end
        w_rst = 1'b0;
        tick();
        n_cmp++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_req: got req=%b addr=%h, expected 1 FFFFFFFC", w_req, w_addr);
        end
        w_gnt = 1'b1;
        tick();
        w_gnt    = 1'b0;
        w_rvalid = 1'b1;
        w_rdata  = 32'h1234_5678;
        tick();
        w_rvalid = 1'b0;
        n_cmp++;
        if (w_valid !== 1'b1 || w_pcf !== 32'hFFFF_FFFC || w_pc4f !== 32'h0 || w_instr !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL wrap_bundle: got valid=%b PCF=%h PC+4=%h instr=%h, expected 1 FFFFFFFC 0 12345678",
                     w_valid, w_pcf, w_pc4f, w_instr);
        end
        n_cmp++;
        if (w_req !== 1'b1 || w_addr !== 32'h0) begin
            n_err++; $display("FAIL wrap_next: got req=%b addr=%h, expected 1 0", w_req, w_addr);
        end
    endtask

`ifdef FETCH_MISALIGN_EN
    task automatic test_misalign();
        do_reset();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (misalign !== 1'b1 || imem_req !== 1'b0 || validf !== 1'b0) begin
            n_err++; $display("FAIL mis_set: got mis=%b req=%b valid=%b, expected 1 0 0", misalign, imem_req, validf);
        end
        gnt_en = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (misalign !== 1'b1 || imem_req !== 1'b0 || issued_q.size() != 0) begin
            n_err++; $display("FAIL mis_halt: got mis=%b req=%b requests=%0d, expected 1 0 0", misalign, imem_req, issued_q.size());
        end
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_err++; $display("FAIL mis_clear: got mis=%b req=%b addr=%h, expected 0 1 200", misalign, imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && issued_q.size() < 1; i++) tick();
        drain_and_check("mis", 1);
    endtask
`endif

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        cyc         = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        gnt_en      = 1'b0;
        drop_en     = 1'b0;
        drop_addr   = 32'h0;
        rsp_delay   = 0;
        n_consumed  = 0;
        w_rst       = 1'b1;
        w_gnt       = 1'b0;
        w_rvalid    = 1'b0;
        w_rdata     = 32'h0;
        w_zero      = 1'b0;
        w_zero32    = 32'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_gnt_stall();
        test_wrap();
`ifdef FETCH_MISALIGN_EN
        test_misalign();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
